// File: rtl/riscv_pkg.sv
// Shared RV32I definitions used across the pipeline blocks.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int INST_WIDTH = 32;

  typedef logic [31:0] inst_t;

  // addi x0, x0, 0
  localparam inst_t NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/instruction_memory.sv
// RV32I instruction memory: zero-latency fetch, synchronous program-load port,
// NOP substitution and a sticky fault flag for misaligned/out-of-range fetches.
module instruction_memory
  import riscv_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INST_WIDTH = 32,
  parameter int                    IMEM_DEPTH = 1024,
  parameter logic [INST_WIDTH-1:0] NOP_INST   = riscv_pkg::NOP_INST
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] Address,
  output logic [INST_WIDTH-1:0] instruction,
  output logic                  misaligned,
  output logic                  out_of_range,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [INST_WIDTH-1:0] load_data,
  output logic                  fault
);

  localparam int IDX_W = $clog2(IMEM_DEPTH);

  logic [INST_WIDTH-1:0] mem [IMEM_DEPTH] = '{default: NOP_INST};

  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] load_idx;
  logic             load_oor;
  logic [1:0]       unused_load_lsb;

  // Any set bit above the index field means the word lies past the array;
  // the upper bits are never dropped, so there is no aliasing on wrap.
  assign fetch_idx    = Address[IDX_W+1:2];
  assign misaligned   = |Address[1:0];
  assign out_of_range = |Address[ADDR_WIDTH-1:IDX_W+2];
  assign instruction  = (misaligned || out_of_range) ? NOP_INST : mem[fetch_idx];

  assign load_idx        = load_addr[IDX_W+1:2];
  assign load_oor        = |load_addr[ADDR_WIDTH-1:IDX_W+2];
  assign unused_load_lsb = load_addr[1:0];

  always_ff @(posedge clk) begin
    if (!rst && load_en && !load_oor) begin
      mem[load_idx] <= load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fault <= 1'b0;
    end else begin
      fault <= fault | misaligned | out_of_range;
    end
  end

endmodule

// File: tb/tb_instruction_memory.sv
// Randomized and directed bench for instruction_memory against an array model.
module tb_instruction_memory;

  localparam int          DEPTH = 16;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Address;
  logic [31:0] instruction;
  logic        misaligned;
  logic        out_of_range;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic        fault;

  always #5 clk = ~clk;

  instruction_memory #(
    .ADDR_WIDTH(32),
    .INST_WIDTH(32),
    .IMEM_DEPTH(DEPTH),
    .NOP_INST  (NOP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .Address     (Address),
    .instruction (instruction),
    .misaligned  (misaligned),
    .out_of_range(out_of_range),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .fault       (fault)
  );

  logic [31:0] ref_mem [DEPTH];
  bit          ref_fault;
  int          n_cmp;
  int          n_err;

  function automatic bit addr_bad(input logic [31:0] a);
    return (a % 4 != 0) || (a / 4 >= DEPTH);
  endfunction

  function automatic logic [31:0] exp_inst(input logic [31:0] a);
    if (addr_bad(a)) return NOP;
    return ref_mem[a / 4];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".inst"}, instruction, exp_inst(Address));
    chk({tag, ".mis"}, {31'b0, misaligned}, {31'b0, (Address % 4 != 0)});
    chk({tag, ".oor"}, {31'b0, out_of_range}, {31'b0, (Address / 4 >= DEPTH)});
    chk({tag, ".fault"}, {31'b0, fault}, {31'b0, ref_fault});
  endtask

  // Model effect of one rising edge, using the inputs held across it.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      ref_fault = 1'b0;
    end else begin
      if (addr_bad(Address)) ref_fault = 1'b1;
      if (load_en && (load_addr / 4 < DEPTH)) ref_mem[load_addr / 4] = load_data;
    end
    #1;
  endtask

  task automatic fetch(input logic [31:0] a, input string tag);
    Address = a;
    #1;
    check_all(tag);
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en   = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6) return $urandom_range(0, DEPTH - 1) * 4;
    if (r < 8) return $urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3);
    if (r == 8) return DEPTH * 4 + $urandom_range(0, 7) * 4;
    return $urandom;
  endfunction

  initial begin
    n_cmp = 0;
    n_err = 0;
    ref_fault = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = NOP;

    rst = 1'b1; Address = 32'd0; load_en = 1'b0; load_addr = 32'd0; load_data = 32'd0;
    tick();
    rst = 1'b0;

    fetch(32'd0, "pwr0");
    fetch(32'd4, "pwr4");
    fetch(32'd8, "pwr8");
    chk("pwr.nop", instruction, 32'h0000_0013);

    load(32'd0, 32'h0010_0093);
    load(32'd4, 32'h01F0_9113);
    load(32'd8, 32'h0FF0_0193);
    fetch(32'd0, "ld0");
    chk("ld0.lit", instruction, 32'h0010_0093);
    fetch(32'd4, "ld4");
    chk("ld4.lit", instruction, 32'h01F0_9113);
    fetch(32'd8, "ld8");
    chk("ld8.lit", instruction, 32'h0FF0_0193);

    fetch(32'd1, "mis1");
    fetch(32'd2, "mis2");
    tick();
    check_all("mis.post");
    chk("mis.fault", {31'b0, fault}, 32'd1);
    fetch(32'd4, "mis.back");
    tick();
    check_all("mis.sticky");

    rst = 1'b1; tick(); rst = 1'b0;
    fetch(4 * (DEPTH - 1), "top");
    tick();
    check_all("top.nofault");
    fetch(4 * DEPTH, "oor");
    chk("oor.nop", instruction, 32'h0000_0013);
    Address = 32'd0;
    load(4 * DEPTH, 32'hDEAD_BEEF);
    fetch(32'd0, "oor.word0");
    chk("oor.word0.lit", instruction, 32'h0010_0093);

    rst = 1'b0; Address = 32'd3; tick();
    chk("rst.pre", {31'b0, fault}, 32'd1);
    rst = 1'b1; load_en = 1'b1; load_addr = 32'd12; load_data = 32'hCAFE_F00D;
    tick();
    rst = 1'b0; load_en = 1'b0;
    chk("rst.fault", {31'b0, fault}, 32'd0);
    fetch(32'd12, "rst.w12");
    chk("rst.w12.lit", instruction, 32'h0000_0013);
    fetch(32'd0, "rst.w0");
    fetch(32'd4, "rst.w4");
    fetch(32'd8, "rst.w8");

    Address = 32'd16; load_en = 1'b1; load_addr = 32'd16; load_data = 32'h00A0_0213;
    #1;
    chk("rdw.old", instruction, 32'h0000_0013);
    tick();
    load_en = 1'b0;
    chk("rdw.new", instruction, 32'h00A0_0213);
    check_all("rdw");

    for (int i = 0; i < 400; i++) begin
      Address   = rand_addr();
      load_en   = $urandom_range(0, 1) == 1;
      load_addr = rand_addr();
      load_data = $urandom;
      rst       = $urandom_range(0, 19) == 0;
      #1;
      check_all("rnd.pre");
      tick();
      check_all("rnd.post");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_memory.md
Name: instruction_memory

Overview:
- Instruction memory for the RV32I 5-stage pipeline; the fetch stage presents the PC and receives the 32-bit instruction in the same cycle (asynchronous read).
- Byte-addressed, word-organised storage with a synchronous program-load write port for the bench/boot loader.
- Flags misaligned and out-of-range fetches; substitutes a NOP for them.
- Sticky fault register for debug.

Parameters:
- ADDR_WIDTH, 32, width of the fetch/load byte address.
- INST_WIDTH, 32, instruction width; fixed at 32, other values unsupported.
- IMEM_DEPTH, 1024, number of 32-bit words; must be a power of two and at least 2.
- NOP_INST, 32'h00000013, value returned for invalid fetches and the power-up content (addi x0,x0,0).

Ports:
- clk, input, 1, clock; load writes and the sticky-flag update on the rising edge.
- rst, input, 1, synchronous active-high reset.
- Address, input, ADDR_WIDTH, fetch byte address (PC).
- instruction, output, INST_WIDTH, fetched instruction; combinational.
- misaligned, output, 1, Address[1:0] != 0; combinational.
- out_of_range, output, 1, word index >= IMEM_DEPTH; combinational.
- load_en, input, 1, program-load write enable.
- load_addr, input, ADDR_WIDTH, program-load byte address; word-aligned.
- load_data, input, INST_WIDTH, program-load instruction word.
- fault, output, 1, sticky OR of misaligned|out_of_range seen at any clock edge since reset.

Behaviour:
- Word index = Address[ADDR_WIDTH-1:2]. Index IMEM_DEPTH-1 is the highest valid word; index IMEM_DEPTH and above is out of range.
- Read is purely combinational with zero latency.
  - instruction = mem[index] when the fetch is aligned and in range.
  - Otherwise instruction = NOP_INST.
- misaligned and out_of_range can both be 1 at the same time; either one forces NOP_INST.
- Every word holds NOP_INST at time zero (initial block). rst does NOT clear or reload the memory array.
- Load write: on posedge clk with load_en=1 and rst=0, write mem[load_addr index] = load_data.
  - load_addr[1:0] is ignored for the write.
  - Writes to an out-of-range index are dropped silently and do not touch the array.
- Read-during-write to the same word: instruction shows the old word until the edge and the new word after it. There is no write-through bypass.
- rst=1 at an edge:
  - fault <= 0.
  - Any load_en in the same cycle is ignored; reset has priority.
- fault, when rst=0 at an edge: fault <= fault | misaligned | out_of_range. It stays 1 until the next rst.
- Reset values:
  - fault = 0.
  - instruction, misaligned and out_of_range are combinational, follow Address and are not reset.
- Address wrap-around: none. An address past the top of the array is always out_of_range and never aliases into the array.

Decomposition:
- Shared package riscv_pkg holds:
  - NOP_INST constant (32'h00000013).
  - XLEN=32 and INST_WIDTH=32.
  - An inst_t typedef (logic [31:0]).
- Single module with no sub-modules. The storage array, read mux, write logic and fault register are simple enough to sit inline.

Test Plan:
- Power-up: Address=0, 4, 8 with no loads -> instruction=32'h00000013; misaligned=0; out_of_range=0; fault=0.
- Load then fetch: load_en=1 writing 32'h00100093 @0, 32'h01F09113 @4, 32'h0FF00193 @8 over three edges. Then Address=0/4/8 -> same words returned with zero latency.
- Misaligned fetch: Address=1, then 2 -> instruction=32'h00000013 and misaligned=1; fault=1 after the next edge. Address=4 -> misaligned=0 while fault stays 1.
- Range: Address=4*(IMEM_DEPTH-1) -> valid word, out_of_range=0. Address=4*IMEM_DEPTH -> NOP and out_of_range=1. A load at 4*IMEM_DEPTH leaves word 0 unchanged.
- Reset: rst=1 with fault=1 and load_en=1 to address 12 -> fault=0 after the edge, word 12 unchanged, and previously loaded words at 0/4/8 still read back.
- Read-during-write: Address=16 while loading 32'h00A00213 @16 -> old value before the edge, 32'h00A00213 immediately after it.
